// File: rtl/fdma_pkg.sv
// Shared definitions for the FDMA AXI read path: burst type, size encoding and
// the read-master state enum.
package fdma_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // Wide enough to hold a full 256-beat burst length.
   localparam int BLEN_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      ADDR,
      DATA,
      DONE
   } state_t;

   function automatic logic [2:0] axi_size_enc(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/fdma_rd_burst_calc.sv
// Combinational burst-length selection for the FDMA read master.
// Build macro FDMA_RD_4K_BOUNDARY_EN additionally stops bursts at 4 KB pages.
module fdma_rd_burst_calc
   import fdma_pkg::*;
#(
   parameter int AXI_DATA_WIDTH    = 128,
   parameter int AXI_ADDR_WIDTH    = 32,
   parameter int AXI_MAX_BURST_LEN = 64
) (
   input  logic [15:0]               remain,
   input  logic [AXI_ADDR_WIDTH-1:0] addr,
   output logic [BLEN_W-1:0]         blen
);

   localparam int BYTES_SHIFT = $clog2(AXI_DATA_WIDTH / 8);

   logic [16:0] lim;
   logic        unused_addr;

   // Only the page offset matters, and only when the boundary clamp is built.
   assign unused_addr = ^addr;

`ifdef FDMA_RD_4K_BOUNDARY_EN
   logic [12:0] room;

   // Beats left before the next 4 KB page; at least 1 for a beat-aligned address.
   assign room = (13'd4096 - {1'b0, addr[11:0]}) >> BYTES_SHIFT;
`endif

   // NOTE: every variable assigned in always_comb gets a value on entry, so no
   // path can leave it holding its old value and infer a latch.
   always_comb begin
      lim = (remain > 16'(AXI_MAX_BURST_LEN)) ? 17'(AXI_MAX_BURST_LEN) : {1'b0, remain};
`ifdef FDMA_RD_4K_BOUNDARY_EN
      if (17'(room) < lim) begin
         lim = 17'(room);
      end
`else
      lim = lim;
`endif
      blen = lim[BLEN_W-1:0];
   end

endmodule

// File: rtl/fdma_axi_rd_master.sv
// FDMA read master: splits one arbitrated read request into AXI4 INCR bursts,
// one outstanding, and streams the data back. See fdma_rd_burst_calc for FDMA_RD_4K_BOUNDARY_EN.
module fdma_axi_rd_master
   import fdma_pkg::*;
#(
   parameter int AXI_DATA_WIDTH    = 128,
   parameter int AXI_ADDR_WIDTH    = 32,
   parameter int AXI_MAX_BURST_LEN = 64
) (
   input  logic                      ui_clk,
   input  logic                      ui_rst,
   input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
   input  logic                      fdma_rareq,
   input  logic [15:0]               fdma_rsize,
   output logic                      fdma_rbusy,
   output logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
   output logic                      fdma_rvalid,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic                      m_axi_rvalid,
   input  logic                      m_axi_rlast,
   output logic                      m_axi_rready
);

   localparam int BYTES_SHIFT = $clog2(AXI_DATA_WIDTH / 8);

   state_t                    state;
   state_t                    state_nxt;
   logic [AXI_ADDR_WIDTH-1:0] addr_r;
   logic [15:0]               remain_r;
   logic [BLEN_W-1:0]         blen_r;
   logic [BLEN_W-1:0]         blen_calc;
   logic [BLEN_W-1:0]         beat_cnt;
   logic                      req_ok;
   logic                      ar_hs;
   logic                      r_hs;
   logic                      burst_end;
   logic                      unused_rlast;

   assign m_axi_arsize  = axi_size_enc(AXI_DATA_WIDTH);
   assign m_axi_arburst = AXI_BURST_INCR;

   // Burst ends are counted locally; rlast is informational only.
   assign unused_rlast = m_axi_rlast;

   assign req_ok    = fdma_rareq && (fdma_rsize != 16'd0);
   assign ar_hs     = m_axi_arvalid && m_axi_arready;
   assign r_hs      = m_axi_rvalid && m_axi_rready;
   assign burst_end = r_hs && (beat_cnt == blen_r - 9'd1);

   fdma_rd_burst_calc #(
      .AXI_DATA_WIDTH    (AXI_DATA_WIDTH),
      .AXI_ADDR_WIDTH    (AXI_ADDR_WIDTH),
      .AXI_MAX_BURST_LEN (AXI_MAX_BURST_LEN)
   ) u_burst_calc (
      .remain (remain_r),
      .addr   (addr_r),
      .blen   (blen_calc)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_ok) state_nxt = CALC;
         CALC:    state_nxt = ADDR;
         ADDR:    if (ar_hs) state_nxt = DATA;
         DATA:    if (burst_end) state_nxt = (remain_r != 16'd0) ? CALC : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decoding from the state register makes reset drop these immediately.
   always_comb begin
      fdma_rbusy    = (state != IDLE);
      m_axi_arvalid = (state == ADDR);
      m_axi_rready  = (state == DATA);
   end

   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         addr_r       <= '0;
         remain_r     <= '0;
         blen_r       <= '0;
         beat_cnt     <= '0;
         m_axi_araddr <= '0;
         m_axi_arlen  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_ok) begin
                  addr_r   <= fdma_raddr;
                  remain_r <= fdma_rsize;
               end
            end
            CALC: begin
               blen_r       <= blen_calc;
               m_axi_araddr <= addr_r;
               m_axi_arlen  <= 8'(blen_calc - 9'd1);
            end
            ADDR: begin
               if (ar_hs) begin
                  addr_r   <= addr_r + (AXI_ADDR_WIDTH'(blen_r) << BYTES_SHIFT);
                  remain_r <= remain_r - 16'(blen_r);
                  beat_cnt <= '0;
               end
            end
            DATA: begin
               if (r_hs) begin
                  beat_cnt <= beat_cnt + 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // One-cycle registered return path; rready is only high in DATA.
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         fdma_rvalid <= 1'b0;
         fdma_rdata  <= '0;
      end else begin
         fdma_rvalid <= r_hs;
         if (r_hs) begin
            fdma_rdata <= m_axi_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fdma_axi_rd_master.sv
// Directed bench for fdma_axi_rd_master with a one-burst AXI read slave model.
// Burst-split expectations follow FDMA_RD_4K_BOUNDARY_EN when it is defined.
module tb_fdma_axi_rd_master;

   logic         ui_clk = 1'b0;
   logic         ui_rst = 1'b1;
   logic [31:0]  fdma_raddr = '0;
   logic         fdma_rareq = 1'b0;
   logic [15:0]  fdma_rsize = '0;
   logic         fdma_rbusy;
   logic [127:0] fdma_rdata;
   logic         fdma_rvalid;
   logic [31:0]  m_axi_araddr;
   logic [7:0]   m_axi_arlen;
   logic [2:0]   m_axi_arsize;
   logic [1:0]   m_axi_arburst;
   logic         m_axi_arvalid;
   logic         m_axi_arready = 1'b0;
   logic [127:0] m_axi_rdata = '0;
   logic         m_axi_rvalid = 1'b0;
   logic         m_axi_rlast = 1'b0;
   logic         m_axi_rready;

   always #5 ui_clk = ~ui_clk;

   fdma_axi_rd_master #(
      .AXI_DATA_WIDTH    (128),
      .AXI_ADDR_WIDTH    (32),
      .AXI_MAX_BURST_LEN (64)
   ) dut (
      .ui_clk        (ui_clk),
      .ui_rst        (ui_rst),
      .fdma_raddr    (fdma_raddr),
      .fdma_rareq    (fdma_rareq),
      .fdma_rsize    (fdma_rsize),
      .fdma_rbusy    (fdma_rbusy),
      .fdma_rdata    (fdma_rdata),
      .fdma_rvalid   (fdma_rvalid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rready  (m_axi_rready)
   );

   // Data content is a function of the beat's byte address, so order is visible.
   function automatic logic [127:0] pat(input logic [31:0] a);
      return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'h1234_5678};
   endfunction

   // ---------------- AXI read slave model ----------------
   logic [31:0] pend_addr[$];
   logic [7:0]  pend_len[$];
   logic [31:0] ar_log_addr[$];
   logic [7:0]  ar_log_len[$];
   int          beat_idx = 0;
   int          ar_wait = 0;
   int          ar_delay = 0;
   bit          rand_r = 1'b0;

   always @(posedge ui_clk) begin
      if (ui_rst) begin
         pend_addr.delete();
         pend_len.delete();
         beat_idx = 0;
         ar_wait  = 0;
      end else begin
         if (m_axi_rvalid && m_axi_rready) begin
            if (beat_idx == int'(pend_len[0])) begin
               void'(pend_addr.pop_front());
               void'(pend_len.pop_front());
               beat_idx = 0;
            end else begin
               beat_idx++;
            end
         end
         if (m_axi_arvalid && m_axi_arready) begin
            pend_addr.push_back(m_axi_araddr);
            pend_len.push_back(m_axi_arlen);
            ar_log_addr.push_back(m_axi_araddr);
            ar_log_len.push_back(m_axi_arlen);
            ar_wait = 0;
         end
      end
      #1;
      if (ui_rst) begin
         m_axi_arready = 1'b0;
         m_axi_rvalid  = 1'b0;
         m_axi_rdata   = '0;
         m_axi_rlast   = 1'b0;
      end else begin
         if (ar_delay == 0) begin
            m_axi_arready = 1'b1;
         end else begin
            m_axi_arready = 1'b0;
            if (m_axi_arvalid) begin
               if (ar_wait >= ar_delay) m_axi_arready = 1'b1;
               else ar_wait++;
            end
         end
         if (pend_addr.size() != 0 && (!rand_r || $urandom_range(0, 1) == 1)) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = pat(pend_addr[0] + 32'(beat_idx * 16));
            m_axi_rlast  = (beat_idx == int'(pend_len[0]));
         end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
         end
      end
   end

   // ---------------- Output monitor (falling edge) ----------------
   int          cyc = 0;
   int          pulse_cnt = 0;
   int          data_err = 0;
   int          stab_err = 0;
   int          busy_falls = 0;
   int          busy_rises = 0;
   int          fall_gap = 0;
   int          last_pulse_cyc = 0;
   logic [31:0] exp_addr = '0;
   logic        prev_busy = 1'b0;
   logic        prev_arvalid = 1'b0;
   logic [31:0] prev_araddr = '0;
   logic [7:0]  prev_arlen = '0;

   always @(negedge ui_clk) begin
      cyc++;
      if (fdma_rbusy && !prev_busy) begin
         exp_addr = fdma_raddr;
         busy_rises++;
      end
      if (!fdma_rbusy && prev_busy) begin
         busy_falls++;
         fall_gap = cyc - last_pulse_cyc;
      end
      if (fdma_rvalid) begin
         pulse_cnt++;
         last_pulse_cyc = cyc;
         if (fdma_rdata !== pat(exp_addr) || !fdma_rbusy) data_err++;
         exp_addr = exp_addr + 32'd16;
      end
      if (prev_arvalid && m_axi_arvalid &&
          (m_axi_araddr !== prev_araddr || m_axi_arlen !== prev_arlen)) stab_err++;
      prev_busy    = fdma_rbusy;
      prev_arvalid = m_axi_arvalid;
      prev_araddr  = m_axi_araddr;
      prev_arlen   = m_axi_arlen;
   end

   // ---------------- Checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   int ar_base = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ui_clk);
      #1;
   endtask

   task automatic request(input logic [31:0] addr, input logic [15:0] size);
      tick(1);
      fdma_raddr = addr;
      fdma_rsize = size;
      fdma_rareq = 1'b1;
      tick(1);
      fdma_rareq = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base_falls, input int budget);
      int k = 0;
      while (busy_falls == base_falls && k < budget) begin
         tick(1);
         k++;
      end
      check({tag, ".completed"}, 1'(busy_falls != base_falls), 1'b1);
   endtask

   task automatic check_ar(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
      logic [31:0] ga = 'x;
      logic [7:0]  gl = 'x;
      if (ar_base + idx < ar_log_addr.size()) begin
         ga = ar_log_addr[ar_base + idx];
         gl = ar_log_len[ar_base + idx];
      end
      check({tag, ".araddr"}, ga, a);
      check({tag, ".arlen"}, gl, l);
   endtask

   // Complete transfer with per-transfer checks; AR contents checked by caller.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic [15:0] size,
                       input int delay, input bit rnd, input int n_ar);
      int base_p = pulse_cnt;
      int base_f = busy_falls;
      int base_d = data_err;
      int base_s = stab_err;
      ar_base  = ar_log_addr.size();
      ar_delay = delay;
      rand_r   = rnd;
      request(addr, size);
      check({tag, ".busy_next"}, fdma_rbusy, 1'b1);
      wait_done(tag, base_f, 3000);
      check({tag, ".pulses"}, 32'(pulse_cnt - base_p), 32'(size));
      check({tag, ".data_order"}, 32'(data_err - base_d), 32'd0);
      check({tag, ".ar_stable"}, 32'(stab_err - base_s), 32'd0);
      check({tag, ".busy_fall_gap"}, 32'(fall_gap), 32'd1);
      check({tag, ".busy_single"}, 32'(busy_falls - base_f), 32'd1);
      check({tag, ".ar_count"}, 32'(ar_log_addr.size() - ar_base), 32'(n_ar));
   endtask

   initial begin
      int base_r;
      int base_p;
      int k;

      // Reset values.
      tick(3);
      check("rst.busy", fdma_rbusy, 1'b0);
      check("rst.rvalid", fdma_rvalid, 1'b0);
      check("rst.rdata", fdma_rdata, 128'd0);
      check("rst.arvalid", m_axi_arvalid, 1'b0);
      check("rst.rready", m_axi_rready, 1'b0);
      check("rst.araddr", m_axi_araddr, 32'd0);
      check("rst.arlen", m_axi_arlen, 8'd0);
      check("rst.arsize", m_axi_arsize, 3'd4);
      check("rst.arburst", m_axi_arburst, 2'b01);
      ui_rst = 1'b0;
      tick(2);

      // Single full-length burst.
      xfer("t1", 32'h0000_1000, 16'd64, 0, 1'b0, 1);
      check_ar("t1.ar0", 0, 32'h0000_1000, 8'd63);

      // Split into 64/64/22.
      xfer("t2", 32'h0000_0000, 16'd150, 0, 1'b0, 3);
      check_ar("t2.ar0", 0, 32'h0000_0000, 8'd63);
      check_ar("t2.ar1", 1, 32'h0000_0400, 8'd63);
      check_ar("t2.ar2", 2, 32'h0000_0800, 8'd21);

      // Transfer straddling a 4 KB page.
`ifdef FDMA_RD_4K_BOUNDARY_EN
      xfer("t3", 32'h0000_0F80, 16'd32, 0, 1'b0, 2);
      check_ar("t3.ar0", 0, 32'h0000_0F80, 8'd7);
      check_ar("t3.ar1", 1, 32'h0000_1000, 8'd23);
`else
      xfer("t3", 32'h0000_0F80, 16'd32, 0, 1'b0, 1);
      check_ar("t3.ar0", 0, 32'h0000_0F80, 8'd31);
`endif

      // Slow arready, random rvalid gaps.
      xfer("t4", 32'h0000_2000, 16'd64, 5, 1'b1, 1);
      check_ar("t4.ar0", 0, 32'h0000_2000, 8'd63);

      // Zero-length request is ignored.
      ar_base = ar_log_addr.size();
      base_r  = busy_rises;
      ar_delay = 0;
      rand_r   = 1'b0;
      request(32'h0000_6000, 16'd0);
      tick(5);
      check("t5.busy", fdma_rbusy, 1'b0);
      check("t5.no_busy_rise", 32'(busy_rises - base_r), 32'd0);
      check("t5.no_ar", 32'(ar_log_addr.size() - ar_base), 32'd0);

      // Second request during busy is ignored.
      ar_base = ar_log_addr.size();
      base_r  = busy_rises;
      base_p  = pulse_cnt;
      k       = busy_falls;
      request(32'h0000_3000, 16'd20);
      tick(3);
      request(32'h0000_9000, 16'd5);
      wait_done("t6", k, 3000);
      tick(5);
      check("t6.pulses", 32'(pulse_cnt - base_p), 32'd20);
      check("t6.one_xfer", 32'(busy_rises - base_r), 32'd1);
      check("t6.busy_after", fdma_rbusy, 1'b0);
      check("t6.ar_count", 32'(ar_log_addr.size() - ar_base), 32'd1);
      check_ar("t6.ar0", 0, 32'h0000_3000, 8'd19);

      // Reset in the middle of a transfer.
      base_p = pulse_cnt;
      request(32'h0000_4000, 16'd64);
      k = 0;
      while (pulse_cnt - base_p < 10 && k < 500) begin
         tick(1);
         k++;
      end
      check("t7.reached_beat10", 1'(pulse_cnt - base_p >= 10), 1'b1);
      ui_rst = 1'b1;
      tick(1);
      check("t7.busy", fdma_rbusy, 1'b0);
      check("t7.rvalid", fdma_rvalid, 1'b0);
      check("t7.rdata", fdma_rdata, 128'd0);
      check("t7.arvalid", m_axi_arvalid, 1'b0);
      check("t7.rready", m_axi_rready, 1'b0);
      check("t7.araddr", m_axi_araddr, 32'd0);
      check("t7.arlen", m_axi_arlen, 8'd0);
      base_p = pulse_cnt;
      tick(3);
      ui_rst = 1'b0;
      tick(3);
      check("t7.no_more_pulses", 32'(pulse_cnt - base_p), 32'd0);
      xfer("t7.after", 32'h0000_5000, 16'd16, 0, 1'b0, 1);
      check_ar("t7.after.ar0", 0, 32'h0000_5000, 8'd15);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed=time limit expected=bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fdma_axi_rd_master.md
Name: fdma_axi_rd_master

Overview:
- Downstream of the four-channel FDMA read arbiter.
- Takes the single arbitrated FDMA read request (address, size in beats) and splits it into AXI4 INCR read bursts.
- Returns the read data to the arbiter as an fdma_rvalid/fdma_rdata stream, and holds fdma_rbusy high for the whole transfer.
- One burst outstanding at a time; drives the AXI read-address and read-data channels toward the DDR controller.

Parameters:
- AXI_DATA_WIDTH, 128, AXI/FDMA data width in bits (power of two, 32..512).
- AXI_ADDR_WIDTH, 32, AXI/FDMA byte-address width.
- AXI_MAX_BURST_LEN, 64, maximum beats per AXI burst (1..256).

Ports:
- ui_clk  in  1  single clock for all logic.
- ui_rst  in  1  asynchronous, active-high reset.
- fdma_raddr  in  AXI_ADDR_WIDTH  start byte address, beat-aligned.
- fdma_rareq  in  1  request; sampled only in IDLE.
- fdma_rsize  in  16  transfer length in beats.
- fdma_rbusy  out  1  transfer in progress.
- fdma_rdata  out  AXI_DATA_WIDTH  read data beat.
- fdma_rvalid  out  1  fdma_rdata valid this cycle.
- m_axi_araddr  out  AXI_ADDR_WIDTH  burst address.
- m_axi_arlen  out  8  burst beats minus 1.
- m_axi_arsize  out  3  clog2(AXI_DATA_WIDTH/8), constant.
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address accepted.
- m_axi_rdata  in  AXI_DATA_WIDTH  read data.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rlast  in  1  last beat of burst; informational only.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset values: every output is 0 (the constant arsize/arburst excepted), and the state machine is in IDLE.
- Reset asserted mid-transfer aborts at once: arvalid, rready and busy drop; no further fdma_rvalid.
- IDLE:
  - On fdma_rareq=1 with fdma_rsize!=0: latch address into addr_r, size into remain_r; fdma_rbusy=1 from the next cycle; go to CALC.
  - fdma_rareq with fdma_rsize=0 is ignored: busy stays 0.
- CALC (1 cycle):
  - blen = min(remain_r, AXI_MAX_BURST_LEN), further limited by the optional feature.
  - Drive m_axi_araddr=addr_r, m_axi_arlen=blen-1, arvalid=1; go to ADDR.
- ADDR:
  - Hold arvalid and the address fields stable until arready=1.
  - On the handshake cycle: arvalid=0; addr_r += blen*(AXI_DATA_WIDTH/8); remain_r -= blen; beat counter = 0; go to DATA.
- DATA:
  - m_axi_rready=1.
  - Each cycle with rvalid&rready: fdma_rdata<=m_axi_rdata and fdma_rvalid<=1 on the next cycle (1-cycle latency); otherwise fdma_rvalid<=0.
  - Burst ends when the beat counter reaches blen; rlast is not used for control.
  - At burst end: if remain_r!=0, go to CALC; otherwise go to DONE.
- DONE (1 cycle):
  - The final fdma_rvalid is output in this cycle.
  - fdma_rbusy goes 0 on the following cycle; return to IDLE.
- The total number of fdma_rvalid pulses equals fdma_rsize exactly.
- fdma_rbusy never drops between bursts of the same transfer.
- fdma_rareq while busy is ignored; the upstream arbiter holds the request until it sees busy.
- Address arithmetic is modulo 2^AXI_ADDR_WIDTH; remain_r is 16 bits wide.
- m_axi_rresp is not monitored.

Optional Feature:
- Macro FDMA_RD_4K_BOUNDARY_EN.
- Defined: blen is additionally limited to (4096 - addr_r[11:0]) / (AXI_DATA_WIDTH/8), so no burst crosses a 4 KB boundary.
- Undefined: no boundary limit; software guarantees transfers that are 4 KB-safe.

Decomposition:
- Shared package fdma_pkg:
  - AXI_BURST_INCR = 2'b01.
  - A function for the arsize encoding from the data width.
  - The state enum IDLE/CALC/ADDR/DATA/DONE.
- One sub-module, fdma_rd_burst_calc: combinational blen computation from remain_r, addr_r and AXI_MAX_BURST_LEN, with the 4 KB clamp under the macro.

Test Plan:
- raddr=0x1000, rsize=64, arready and rvalid always 1:
  - One AR with arlen=63, araddr=0x1000.
  - 64 fdma_rvalid pulses with data in order.
  - busy high from the cycle after rareq until the cycle after the last pulse.
- rsize=150, MAX=64:
  - Three ARs with arlen 63/63/21 at 0x0, 0x400, 0x800.
  - busy continuously high; exactly 150 pulses.
- Macro defined, raddr=0x0F80, rsize=32:
  - Two ARs: arlen=7 at 0x0F80, then arlen=23 at 0x1000.
  - Macro undefined: a single arlen=31.
- arready delayed 5 cycles and rvalid toggling randomly:
  - Address fields stable while arvalid is high.
  - fdma_rvalid count is 64, data order preserved.
- rareq with rsize=0 → busy stays 0 and no AR is issued.
- A second rareq during busy → ignored.
- ui_rst asserted on the 10th beat of a 64-beat read:
  - All outputs are 0 on the next edge.
  - A new request after reset completes normally.
